// File: rtl/next_line_propagate.sv
// Propagates a connected-domain mask from the previous image row into the
// current one: reads the row from BRAM, flood-fills from the seed, writes it back.
module next_line_propagate #(
  parameter int CONNECT8 = 1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_trig,
  output logic         o_done,
  input  logic [8:0]   i_row_num,
  input  logic [511:0] i_prev_mask,
  output logic [12:0]  o_rd_from_bram_addr,
  input  logic [31:0]  i_rd_from_bram_data,
  output logic         o_rd_from_bram_trig,
  input  logic         i_rd_from_bram_done,
  output logic [12:0]  o_wr_to_bram_addr,
  output logic [31:0]  o_wr_to_bram_data,
  output logic         o_wr_to_bram_trig,
  input  logic         i_wr_to_bram_done,
  output logic [511:0] o_512b_mask,
  output logic         o_mask_empty,
  output logic [2:0]   o_dbg_state
);

  // Both BRAM buses: trig rises the cycle after *_REQ, stays high with a
  // stable address/data until done is sampled high, then drops for at least
  // one cycle before the next word. done is only looked at while trig is high.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    GROW    = 3'd3,
    WR_REQ  = 3'd4,
    WR_WAIT = 3'd5,
    DONE    = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     k_q, k_d;
  logic [8:0]     row_num_q, row_num_d;
  logic [511:0]   prev_q, prev_d;
  logic [511:0]   row_q, row_d;
  logic [511:0]   fill_q, fill_d;
  logic [12:0]    rd_addr_q, rd_addr_d;
  logic           rd_trig_q, rd_trig_d;
  logic [12:0]    wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           wr_trig_q, wr_trig_d;
  logic [511:0]   mask_q, mask_d;
  logic           empty_q, empty_d;

  function automatic logic [511:0] spread(input logic [511:0] v);
    return v | (v << 1) | (v >> 1);
  endfunction

  logic [511:0] near_prev;
  logic [511:0] grow_step;

  assign near_prev = (CONNECT8 != 0) ? spread(prev_q) : prev_q;
  assign grow_step = row_q & spread(fill_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    row_num_d = row_num_q;
    prev_d    = prev_q;
    row_d     = row_q;
    fill_d    = fill_q;
    rd_addr_d = rd_addr_q;
    rd_trig_d = rd_trig_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_trig_d = wr_trig_q;
    mask_d    = mask_q;
    empty_d   = empty_q;
    case (state_q)
      IDLE: begin
        if (i_trig) begin
          row_num_d = i_row_num;
          prev_d    = i_prev_mask;
          k_d       = 4'd0;
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        rd_addr_d = {row_num_q, k_q};
        rd_trig_d = 1'b1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_trig_q && i_rd_from_bram_done) begin
          row_d[{k_q, 5'd0} +: 32] = i_rd_from_bram_data;
          rd_trig_d = 1'b0;
          if (k_q == 4'd15) begin
            k_d     = 4'd0;
            // Seed uses the fully assembled row, including the word just read.
            fill_d  = row_d & near_prev;
            state_d = GROW;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = RD_REQ;
          end
        end
      end
      GROW: begin
        if (grow_step == fill_q) begin
          mask_d  = fill_q;
          empty_d = (fill_q == '0);
          state_d = WR_REQ;
        end else begin
          fill_d = grow_step;
        end
      end
      WR_REQ: begin
        wr_addr_d = {row_num_q, k_q};
        wr_data_d = fill_q[{k_q, 5'd0} +: 32];
        wr_trig_d = 1'b1;
        state_d   = WR_WAIT;
      end
      WR_WAIT: begin
        if (wr_trig_q && i_wr_to_bram_done) begin
          wr_trig_d = 1'b0;
          if (k_q == 4'd15) begin
            k_d     = 4'd0;
            state_d = DONE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = WR_REQ;
          end
        end
      end
      DONE: begin
        if (!i_trig) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      k_q       <= '0;
      row_num_q <= '0;
      prev_q    <= '0;
      row_q     <= '0;
      fill_q    <= '0;
      rd_addr_q <= '0;
      rd_trig_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_trig_q <= 1'b0;
      mask_q    <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      row_num_q <= row_num_d;
      prev_q    <= prev_d;
      row_q     <= row_d;
      fill_q    <= fill_d;
      rd_addr_q <= rd_addr_d;
      rd_trig_q <= rd_trig_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_trig_q <= wr_trig_d;
      mask_q    <= mask_d;
      empty_q   <= empty_d;
    end
  end

  assign o_done              = (state_q == DONE);
  assign o_rd_from_bram_addr = rd_addr_q;
  assign o_rd_from_bram_trig = rd_trig_q;
  assign o_wr_to_bram_addr   = wr_addr_q;
  assign o_wr_to_bram_data   = wr_data_q;
  assign o_wr_to_bram_trig   = wr_trig_q;
  assign o_512b_mask         = mask_q;
  assign o_mask_empty        = empty_q;
  assign o_dbg_state         = state_q;

endmodule

// File: tb/tb_next_line_propagate.sv
// Directed bench for next_line_propagate: a table of rows/seeds with hand-computed
// masks, run through a BRAM model, plus reset-mid-write and trig-hold sequences.
module tb_next_line_propagate;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GROW    = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         trig, sel;
  logic [8:0]   row_num;
  logic [511:0] prev_mask;
  logic [31:0]  rd_data;
  logic         rd_done, wr_done;

  logic         d8_done, d8_rd_trig, d8_wr_trig, d8_empty;
  logic [12:0]  d8_rd_addr, d8_wr_addr;
  logic [31:0]  d8_wr_data;
  logic [511:0] d8_mask;
  logic [2:0]   d8_state;
  logic         d4_done, d4_rd_trig, d4_wr_trig, d4_empty;
  logic [12:0]  d4_rd_addr, d4_wr_addr;
  logic [31:0]  d4_wr_data;
  logic [511:0] d4_mask;
  logic [2:0]   d4_state;
  logic         t8, t4;

  assign t8 = trig & ~sel;
  assign t4 = trig & sel;

  next_line_propagate #(.CONNECT8(1)) dut8 (
    .i_clk(clk), .i_rstn(rst_n), .i_trig(t8), .o_done(d8_done),
    .i_row_num(row_num), .i_prev_mask(prev_mask),
    .o_rd_from_bram_addr(d8_rd_addr), .i_rd_from_bram_data(rd_data),
    .o_rd_from_bram_trig(d8_rd_trig), .i_rd_from_bram_done(rd_done),
    .o_wr_to_bram_addr(d8_wr_addr), .o_wr_to_bram_data(d8_wr_data),
    .o_wr_to_bram_trig(d8_wr_trig), .i_wr_to_bram_done(wr_done),
    .o_512b_mask(d8_mask), .o_mask_empty(d8_empty), .o_dbg_state(d8_state)
  );

  next_line_propagate #(.CONNECT8(0)) dut4 (
    .i_clk(clk), .i_rstn(rst_n), .i_trig(t4), .o_done(d4_done),
    .i_row_num(row_num), .i_prev_mask(prev_mask),
    .o_rd_from_bram_addr(d4_rd_addr), .i_rd_from_bram_data(rd_data),
    .o_rd_from_bram_trig(d4_rd_trig), .i_rd_from_bram_done(rd_done),
    .o_wr_to_bram_addr(d4_wr_addr), .o_wr_to_bram_data(d4_wr_data),
    .o_wr_to_bram_trig(d4_wr_trig), .i_wr_to_bram_done(wr_done),
    .o_512b_mask(d4_mask), .o_mask_empty(d4_empty), .o_dbg_state(d4_state)
  );

  // Selected DUT as seen by the BRAM model and the checks.
  logic         b_done, b_rd_trig, b_wr_trig, b_empty;
  logic [12:0]  b_rd_addr, b_wr_addr;
  logic [31:0]  b_wr_data;
  logic [511:0] b_mask;
  logic [2:0]   b_state;
  always_comb begin
    b_done    = sel ? d4_done    : d8_done;
    b_rd_trig = sel ? d4_rd_trig : d8_rd_trig;
    b_wr_trig = sel ? d4_wr_trig : d8_wr_trig;
    b_empty   = sel ? d4_empty   : d8_empty;
    b_rd_addr = sel ? d4_rd_addr : d8_rd_addr;
    b_wr_addr = sel ? d4_wr_addr : d8_wr_addr;
    b_wr_data = sel ? d4_wr_data : d8_wr_data;
    b_mask    = sel ? d4_mask    : d8_mask;
    b_state   = sel ? d4_state   : d8_state;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [44:0] exp_q[$];
  logic [12:0] exp_rd_q[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- BRAM model ----------------
  logic [31:0] mem [0:8191];
  int  max_wait = 0;
  bit  noise = 1'b0;
  bit  rd_busy, wr_busy, rd_trig_prev, wr_trig_prev;
  int  rd_left, wr_left;
  int  rd_xfers, wr_xfers, rd_rises, wr_rises, overlaps;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_done = 1'b0; wr_done = 1'b0; rd_busy = 1'b0; wr_busy = 1'b0;
      rd_trig_prev = 1'b0; wr_trig_prev = 1'b0;
    end else begin
      if (b_rd_trig && b_wr_trig) overlaps++;
      if (b_rd_trig && !rd_trig_prev) rd_rises++;
      if (b_wr_trig && !wr_trig_prev) wr_rises++;
      rd_trig_prev = b_rd_trig;
      wr_trig_prev = b_wr_trig;
      if (rd_done) rd_done = 1'b0;
      else if (b_rd_trig) begin
        if (!rd_busy) begin rd_busy = 1'b1; rd_left = $urandom_range(0, max_wait); end
        if (rd_left == 0) begin
          logic [12:0] ea;
          rd_busy = 1'b0;
          rd_data = mem[b_rd_addr];
          rd_done = 1'b1;
          rd_xfers++;
          ea = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 13'h1FFF;
          check("rd_addr", b_rd_addr, ea);
        end else rd_left--;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        rd_data = 32'hDEADBEEF;
        rd_done = 1'b1;
      end
      if (wr_done) wr_done = 1'b0;
      else if (b_wr_trig) begin
        if (!wr_busy) begin wr_busy = 1'b1; wr_left = $urandom_range(0, max_wait); end
        if (wr_left == 0) begin
          logic [44:0] ew;
          wr_busy = 1'b0;
          mem[b_wr_addr] = b_wr_data;
          wr_done = 1'b1;
          wr_xfers++;
          ew = (exp_q.size() > 0) ? exp_q.pop_front() : 45'h1FFF_FFFFFFFF;
          check("wr_addr_data", {b_wr_addr, b_wr_data}, ew);
        end else wr_left--;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        wr_done = 1'b1;
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic         c8;
    logic [8:0]   row;
    logic [511:0] row_bits;
    logic [511:0] prev;
    logic [511:0] exp_mask;
    logic         exp_empty;
    int           mw;
    bit           nz;
    int           hold;
  } vec_t;
  vec_t tv[7];

  // ---------------- driver tasks ----------------
  task automatic start_case(input int i);
    for (int k = 0; k < 16; k++) begin
      mem[{tv[i].row, 4'(k)}] = tv[i].row_bits[32*k +: 32];
      exp_rd_q.push_back({tv[i].row, 4'(k)});
      exp_q.push_back({tv[i].row, 4'(k), tv[i].exp_mask[32*k +: 32]});
    end
    sel = ~tv[i].c8;
    max_wait = tv[i].mw;
    noise = tv[i].nz;
    rd_xfers = 0; wr_xfers = 0; rd_rises = 0; wr_rises = 0; overlaps = 0;
    row_num = tv[i].row;
    prev_mask = tv[i].prev;
    trig = 1'b1;
    @(negedge clk);
    // Inputs are latched by now; scrambling them must not affect the run.
    row_num = 9'($urandom);
    prev_mask = {16{$urandom}};
  endtask

  task automatic finish_case(input int i, input string tag);
    int cyc = 0;
    int grow = 0;
    bit seen = 1'b0;
    while (cyc < 4000 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (b_state == S_GROW) grow++;
      if (b_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_mask"}, b_mask, tv[i].exp_mask);
    check({tag, "_empty"}, b_empty, tv[i].exp_empty);
    check({tag, "_rd_xfers"}, rd_xfers, 16);
    check({tag, "_wr_xfers"}, wr_xfers, 16);
    check({tag, "_rd_pulses"}, rd_rises, 16);
    check({tag, "_wr_pulses"}, wr_rises, 16);
    check({tag, "_trig_overlap"}, overlaps, 0);
    check({tag, "_wr_left"}, exp_q.size(), 0);
    check({tag, "_rd_left"}, exp_rd_q.size(), 0);
    if (tv[i].row_bits == '1) check({tag, "_grow_511"}, (grow >= 510 && grow <= 512), 1);
    else check({tag, "_grow_range"}, (grow >= 1 && grow <= 512), 1);
    for (int j = 0; j < tv[i].hold; j++) begin
      @(posedge clk); #1;
      check({tag, "_hold_done"}, {b_state, b_done, b_rd_trig}, {S_DONE, 1'b1, 1'b0});
    end
    @(negedge clk);
    trig = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_after_trig"}, {b_state, b_done}, {S_IDLE, 1'b0});
    check({tag, "_mask_held"}, b_mask, tv[i].exp_mask);
    noise = 1'b0;
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 7; i++) begin
      tv[i] = '{c8: 1'b1, row: 9'd0, row_bits: '0, prev: '0, exp_mask: '0,
                exp_empty: 1'b0, mw: 0, nz: 1'b0, hold: 0};
    end
    // One run of 8 pixels seeded from the middle.
    tv[0].row = 9'd21; tv[0].row_bits[31:0] = 32'h0000FF00; tv[0].prev[12] = 1'b1;
    tv[0].exp_mask[31:0] = 32'h0000FF00; tv[0].hold = 10;
    // Full row, seed at the far edge: fill crawls across all 512 bits.
    tv[1].row = 9'd5; tv[1].row_bits = '1; tv[1].prev[511] = 1'b1; tv[1].exp_mask = '1;
    // Diagonal neighbour: connected with 8-connectivity only.
    tv[2].row = 9'd7; tv[2].row_bits[5] = 1'b1; tv[2].row_bits[40] = 1'b1;
    tv[2].prev[6] = 1'b1; tv[2].exp_mask[5] = 1'b1;
    tv[3] = tv[2]; tv[3].c8 = 1'b0; tv[3].exp_mask = '0; tv[3].exp_empty = 1'b1;
    // Empty previous mask wipes the row.
    tv[4].row = 9'd3; tv[4].row_bits = {16{32'hA5A5A5A5}}; tv[4].exp_empty = 1'b1;
    // Random BRAM latency, stray done pulses, two separate components.
    tv[5].row = 9'd100; tv[5].row_bits[127:96] = 32'h000F00F0;
    tv[5].row_bits[511:480] = 32'h80000001;
    tv[5].prev[101] = 1'b1; tv[5].prev[510] = 1'b1;
    tv[5].exp_mask[127:96] = 32'h000000F0; tv[5].exp_mask[511:480] = 32'h80000000;
    tv[5].mw = 7; tv[5].nz = 1'b1;
    tv[6].row = 9'd0; tv[6].row_bits[31:0] = 32'h00000003; tv[6].prev[1] = 1'b1;
    tv[6].exp_mask[31:0] = 32'h00000003;

    rst_n = 1'b0; trig = 1'b0; sel = 1'b0; row_num = '0; prev_mask = '0;
    rd_data = '0; rd_done = 1'b0; wr_done = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {d8_state, d8_done, d8_rd_trig, d8_wr_trig, d8_empty, d8_rd_addr},
          {S_IDLE, 4'b0, 13'h0});
    check("reset_mask", d8_mask, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      start_case(i);
      finish_case(i, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Reset while word 7 is being written.
    start_case(6);
    begin
      int cyc = 0;
      bit hit = 1'b0;
      while (cyc < 2000 && !hit) begin
        @(posedge clk); #1;
        cyc++;
        if (b_state == S_WR_WAIT && b_wr_addr[3:0] == 4'd7) hit = 1'b1;
      end
      check("rst_reached_wr7", hit, 1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {b_state, b_done, b_rd_trig, b_wr_trig, b_empty},
          {S_IDLE, 4'b0});
    check("rst_async_bus", {b_rd_addr, b_wr_addr, b_wr_data}, 0);
    check("rst_async_mask", b_mask, 0);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_rd_q.delete();
    repeat (3) @(posedge clk);
    #1 check("rst_stays_idle", {b_state, b_rd_trig}, {S_IDLE, 1'b0});
    @(negedge clk);
    start_case(6);
    finish_case(6, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/next_line_propagate.md
NEXT_LINE_PROPAGATE -- requirements
Module: next_line_propagate

Interface
REQ-001 SHALL have parameter CONNECT8, default 1, meaning 1 = 8-connectivity seed, 0 = 4-connectivity seed.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_trig, input, 1, start request, held high by the controller until o_done is seen.
REQ-005 SHALL have port o_done, output, 1, completion flag.
REQ-006 SHALL have port i_row_num, input, 9, row to process (0..511).
REQ-007 SHALL have port i_prev_mask, input, 512, connected-domain mask of the previous row.
REQ-008 SHALL have ports o_rd_from_bram_addr (output, 13), i_rd_from_bram_data (input, 32), o_rd_from_bram_trig (output, 1) and i_rd_from_bram_done (input, 1), forming the BRAM read bus.
REQ-009 SHALL have ports o_wr_to_bram_addr (output, 13), o_wr_to_bram_data (output, 32), o_wr_to_bram_trig (output, 1) and i_wr_to_bram_done (input, 1), forming the BRAM write bus.
REQ-010 SHALL have port o_512b_mask, output, 512, filtered row mask, the input for the next row.
REQ-011 SHALL have port o_mask_empty, output, 1, high when o_512b_mask is all zero at done.

Function
REQ-012 SHALL implement states IDLE, RD_REQ, RD_WAIT, GROW, WR_REQ, WR_WAIT and DONE.
REQ-013 SHALL, in IDLE with i_trig=1, latch i_row_num and i_prev_mask, clear word index k to 0, and go to RD_REQ.
REQ-014 SHALL form BRAM addresses as {row, k[3:0]}; word k maps to row bits [32k+31:32k], bit 0 = leftmost pixel.
REQ-015 SHALL, for the read handshake, hold trig=1 with a stable address from RD_REQ until done=1 is sampled, capture the data on that same edge, drop trig the next cycle, then advance k; after k=15, clear k and go to GROW.
REQ-016 SHALL, on GROW entry, compute seed = row & (prev | prev<<1 | prev>>1) when CONNECT8=1, and seed = row & prev when CONNECT8=0.
REQ-017 SHALL treat bits shifted in past bit 0 or bit 511 as 0.
REQ-018 SHALL, in GROW, perform one fill = row & (fill | fill<<1 | fill>>1) step per cycle, and leave GROW the first cycle the fill is unchanged; GROW SHALL last 1 to 512 cycles.
REQ-019 SHALL write 16 words of fill to the same row addresses in order k=0..15, using the same trig/done rules as the read bus.
REQ-020 SHALL drive o_wr_to_bram_data stable while o_wr_to_bram_trig=1.
REQ-021 SHALL, in DONE, hold o_done=1, o_512b_mask=fill and o_mask_empty=(fill==0), and stay in DONE until i_trig=0, then return to IDLE.
REQ-022 SHALL hold o_512b_mask until the next GROW completes.
REQ-023 SHALL never assert rd trig and wr trig in the same cycle.
REQ-024 SHALL ignore i_rd_from_bram_done and i_wr_to_bram_done when the matching trig is low.
REQ-025 SHALL ignore i_trig outside IDLE and DONE, and SHALL NOT change i_row_num or i_prev_mask latched values until the next IDLE start.
REQ-026 SHALL produce an all-zero row write, o_mask_empty=1 and o_done=1 when i_prev_mask=0.

Reset
REQ-027 SHALL, on i_rstn=0 at any time including mid-transfer, immediately set state to IDLE and all outputs (o_done, both trigs, addresses, write data, o_512b_mask, o_mask_empty) to 0.
REQ-028 SHALL clear k and the internal row/fill registers to 0 on reset.
REQ-029 SHALL resume only on the first i_trig=1 sampled after i_rstn rises.

Verification
REQ-030 SHALL be verified with row 21 = 0x0000FF00 in word 0 and zeros elsewhere, prev mask bit 12 set, CONNECT8=1: written word 0 SHALL be 0x0000FF00, other words 0, o_mask_empty=0, and read addresses SHALL be 0x150..0x15F.
REQ-031 SHALL be verified with row words all 0xFFFFFFFF and prev mask bit 511 only: the fill SHALL span all 512 bits, GROW SHALL be about 511 cycles, and o_512b_mask SHALL be all ones.
REQ-032 SHALL be verified with row bit 5 and bit 40 set and prev bit 6 only, run once with CONNECT8=1 and once with CONNECT8=0: output SHALL be bit 5 only for CONNECT8=1, and zero with o_mask_empty=1 for CONNECT8=0.
REQ-033 SHALL be verified with a BRAM model inserting 0-7 random wait cycles before done: the result SHALL be identical, with exactly 16 read and 16 write transactions and one trig pulse per word.
REQ-034 SHALL be verified with reset asserted during WR_WAIT of word 7: outputs SHALL go 0 asynchronously, and a new trigger on row 0 SHALL complete normally with addresses 0x000..0x00F.
REQ-035 SHALL be verified with i_trig held high for 10 cycles after o_done: no second run SHALL start, and IDLE SHALL be re-entered one cycle after i_trig falls.
